// File: rtl/serial_mag_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, decision codes
// and the slice-counter width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    EQ,
    AG,
    BG
  } dec_t;

  // Counter must hold WIDTH/DIGIT, the number of slices per comparison.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Start/operand/result bundle of the serial magnitude comparator.
interface serial_mag_comparator_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             ag;
  logic             bg;

  modport master (output start, a, b, input busy, done, eq, ag, bg);
  modport slave  (input start, a, b, output busy, done, eq, ag, bg);

endinterface

// File: rtl/serial_mag_comparator_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_comparator #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             ag,
  output logic             bg
);

  assign eq = (a == b);
  assign ag = (a > b);
  assign bg = (a < b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial unsigned magnitude comparator, DIGIT bits per cycle, MSB slice first.
// Define CMP_EARLY_EXIT_EN to finish as soon as the first differing slice is seen.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic                    clk,
  input logic                    rst,
  serial_mag_comparator_if.slave bus
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = cnt_width(WIDTH, DIGIT);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state_reg;
  dec_t             dec_reg;
  dec_t             dec_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             eq_reg;
  logic             ag_reg;
  logic             bg_reg;

  logic slice_eq;
  logic slice_ag;
  logic slice_bg;
  logic run_last;

  digit_comparator #(.DIGIT(DIGIT)) u_digit (
    .a  (a_sh_reg[WIDTH-1 -: DIGIT]),
    .b  (b_sh_reg[WIDTH-1 -: DIGIT]),
    .eq (slice_eq),
    .ag (slice_ag),
    .bg (slice_bg)
  );

  // The first differing slice decides; later slices never override it.
  always_comb begin
    dec_next = dec_reg;
    if (dec_reg == EQ && !slice_eq) begin
      dec_next = slice_ag ? AG : BG;
    end
  end

`ifdef CMP_EARLY_EXIT_EN
  assign run_last = (cnt_reg == CW'(1)) || (dec_reg == EQ && slice_bg != slice_ag);
`else
  assign run_last = (cnt_reg == CW'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dec_reg   <= EQ;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      eq_reg    <= 1'b0;
      ag_reg    <= 1'b0;
      bg_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            cnt_reg   <= CW'(NSLICE);
            dec_reg   <= EQ;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg << DIGIT;
          b_sh_reg <= b_sh_reg << DIGIT;
          cnt_reg  <= cnt_reg - CW'(1);
          dec_reg  <= dec_next;
          if (run_last) begin
            // Results only change here, so they hold across the next run.
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            eq_reg    <= (dec_next == EQ);
            ag_reg    <= (dec_next == AG);
            bg_reg    <= (dec_next == BG);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.eq   = eq_reg;
  assign bus.ag   = ag_reg;
  assign bus.bg   = bg_reg;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator: an 8/2 instance and a 4/1 instance.
module tb_serial_mag_comparator;
  import cmp_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_mag_comparator_if #(.WIDTH(8)) if8 ();
  serial_mag_comparator_if #(.WIDTH(4)) if4 ();

  serial_mag_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  serial_mag_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Runs one comparison on the 8-bit instance; latency counts from the start cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [2:0] exp_res);
    int lat;
    int busy_cnt;
    if8.a     = a;
    if8.b     = b;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    if8.a     = ~a;
    if8.b     = ~b;
    lat       = 1;
    busy_cnt  = 0;
    while (!if8.done && lat < 20) begin
      if (if8.busy) busy_cnt++;
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, busy_cnt, exp_lat - 1);
    chk({tag, "_res"}, int'({if8.eq, if8.ag, if8.bg}), int'(exp_res));
    $display("op %s a=%02h b=%02h latency=%0d eq/ag/bg=%b", tag, a, b, lat,
             {if8.eq, if8.ag, if8.bg});
  endtask

  initial begin
    int         bad_done;
    int         lat;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [2:0] exp_res;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    if8.start = 1'b0;
    if8.a     = '0;
    if8.b     = '0;
    if4.start = 1'b0;
    if4.a     = '0;
    if4.b     = '0;
    tick();
    tick();
    chk("reset_outs", int'({if8.busy, if8.done, if8.eq, if8.ag, if8.bg}), 0);
    chk("reset_state", int'(dut8.state_reg), int'(IDLE));
    rst = 1'b0;

    // Greater, differing only in the last slice.
    run_op("greater", 8'hA5, 8'hA4, 5, 3'b010);
    tick();
    chk("hold_after_done", int'({if8.done, if8.eq, if8.ag, if8.bg}), 4'b0010);

    // Early-exit candidates.
    run_op("early_s1", 8'h40, 8'h80, EARLY ? 2 : 5, 3'b001);
    run_op("early_s2", 8'h10, 8'h20, EARLY ? 3 : 5, 3'b001);
    run_op("sticky",   8'h40, 8'h3F, EARLY ? 2 : 5, 3'b010);
    run_op("equal",    8'hFF, 8'hFF, 5, 3'b100);
    run_op("zeros",    8'h00, 8'h00, 5, 3'b100);

    // Async reset between edges clears results immediately.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", int'({if8.busy, if8.done, if8.eq, if8.ag, if8.bg}), 0);
    chk("async_rst_state", int'(dut8.state_reg), int'(IDLE));
    #1 rst = 1'b0;
    tick();

    // Start held high; only pairs presented in IDLE/DONE cycles count.
    for (int k = 0; k < 15; k++) begin
      if (k == 0)       begin pa = 8'h03; pb = 8'h02; end
      else if (k == 5)  begin pa = 8'h02; pb = 8'h03; end
      else if (k == 10) begin pa = 8'h43; pb = 8'h42; end
      else              begin pa = 8'(k); pb = 8'(k); end
      if8.a     = pa;
      if8.b     = pb;
      if8.start = 1'b1;
      tick();
      chk($sformatf("b2b_done_c%0d", k + 1), int'(if8.done), int'((k + 1) % 5 == 0));
      chk($sformatf("b2b_busy_c%0d", k + 1), int'(if8.busy), int'((k + 1) % 5 != 0));
      if ((k + 1) % 5 == 0) begin
        exp_res = ((k + 1) == 10) ? 3'b001 : 3'b010;
        chk($sformatf("b2b_res_c%0d", k + 1), int'({if8.eq, if8.ag, if8.bg}), int'(exp_res));
        $display("b2b done at cycle %0d eq/ag/bg=%b", k + 1, {if8.eq, if8.ag, if8.bg});
      end
    end
    if8.start = 1'b0;
    tick();

    // Abort during the second RUN cycle.
    if8.a     = 8'hFF;
    if8.b     = 8'h00;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", int'({if8.busy, if8.done, if8.eq, if8.ag, if8.bg}), 0);
    chk("abort_state", int'(dut8.state_reg), int'(IDLE));
    #1 rst = 1'b0;
    bad_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (if8.done) bad_done++;
    end
    chk("abort_no_done", bad_done, 0);
    $display("abort: done pulses after reset=%0d", bad_done);
    run_op("after_abort", 8'h3C, 8'h3C, 5, 3'b100);

    // Exhaustive 4-bit, one bit per cycle.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        if4.a     = 4'(i);
        if4.b     = 4'(j);
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        lat       = 1;
        while (!if4.done && lat < 10) begin
          tick();
          lat++;
        end
        exp_res = (i == j) ? 3'b100 : (i > j) ? 3'b010 : 3'b001;
        chk($sformatf("exh_%0d_%0d", i, j), int'({if4.done, if4.eq, if4.ag, if4.bg}),
            int'({1'b1, exp_res}));
        $display("exh a=%0d b=%0d latency=%0d eq/ag/bg=%b", i, j, lat,
                 {if4.eq, if4.ag, if4.bg});
      end
    end
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
